cond_logic: RTL and testbench
=============================

# cond_logic

Condition and flag-state stage sitting directly downstream of the ALU in the single-cycle ARM datapath. It holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against the stored flags. It gates the decoder's PCS/RegW/MemW requests into the final PCSrc/RegWrite/MemWrite strobes and updates the flags from ALUFlags when the instruction executes. Optional saturating counters record executed and squashed instructions for debug.

## Interface
- No parameters; all widths fixed.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- Valid  in  1  instruction in execute this cycle; when low, no flag/counter update and all strobes low
- Cond  in  4  instruction condition field, Instr[31:28]
- ALUFlags  in  4  {N,Z,C,V} from the ALU, same cycle
- FlagW  in  2  [1]=write N,Z; [0]=write C,V
- PCS  in  1  decoder: instruction writes PC
- RegW  in  1  decoder: instruction writes register file
- MemW  in  1  decoder: instruction writes memory
- NoWrite  in  1  decoder: suppress RegWrite (CMP/CMN/TST/TEQ)
- PCSrc  out  1  PCS & CondEx & Valid
- RegWrite  out  1  RegW & ~NoWrite & CondEx & Valid
- MemWrite  out  1  MemW & CondEx & Valid
- CondEx  out  1  condition passes against stored Flags
- Flags  out  4  stored {N,Z,C,V}
- ExecCount  out  16  executed-instruction count
- SquashCount  out  16  squashed-instruction count

## Operation
- Condition evaluated on the stored Flags register, never on same-cycle ALUFlags.
- Cond map: 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.
- Flag update at clock edge when Valid & CondEx: FlagW[1] loads Flags[3:2] <= ALUFlags[3:2]; FlagW[0] loads Flags[1:0] <= ALUFlags[1:0]; halves independent; unselected half holds.
- Squashed instruction (CondEx=0) never updates flags, even if FlagW nonzero.
- Counters: Valid & CondEx increments ExecCount; Valid & ~CondEx increments SquashCount; each saturates at 16'hFFFF. Valid=0 leaves both unchanged.
- PCSrc/RegWrite/MemWrite/CondEx are combinational from current inputs and stored Flags; no storage in the strobe path.

## Timing
- Reset (synchronous, sampled at rising edge): Flags=4'b0000, ExecCount=0, SquashCount=0. Post-reset combinational outputs follow from Flags=0: e.g. Cond=EQ -> CondEx=0; Cond=NE -> CondEx=1.
- reset dominates Valid/FlagW in the same cycle: flags and counters clear, no update.
- Strobe latency: 0 cycles (same cycle as inputs).
- Flag latency: 1 cycle; result of instruction N is visible to condition of instruction N+1.
- Back-to-back flag-setting instructions: each edge loads the latest ALUFlags; no hazard, no stall.
- Reset mid-program: next cycle evaluates against cleared flags.

## Configuration
- COND_COUNTERS_EN defined: ExecCount/SquashCount registers and saturation logic present as above.
- Undefined: counter registers omitted; ExecCount and SquashCount tied to 16'h0000; all other behaviour identical.

## Test plan
- Reset, then Valid=1, Cond=1110, RegW=1, FlagW=11, ALUFlags=0100 -> RegWrite=1 same cycle; next cycle Flags=0100; with Cond=0000 next, CondEx=1.
- Flags=0100, Cond=0001 (NE), PCS=1, MemW=1, FlagW=11, ALUFlags=1000 -> PCSrc=0, MemWrite=0, Flags stay 0100, SquashCount+1.
- Flags=0000, Valid=1, Cond=AL, FlagW=10, ALUFlags=1111 -> Flags=1100 (C,V held); then FlagW=01, ALUFlags=0011 -> Flags=1111.
- Sweep all 16 Cond codes for each of 16 Flags values -> CondEx matches table; 1111 always 0; NoWrite=1 with RegW=1 -> RegWrite=0.
- With COND_COUNTERS_EN, preload by 65535 executed cycles then one more -> ExecCount=FFFF (saturated); Valid=0 cycles -> no change; reset -> 0.
- Valid=0 with FlagW=11, ALUFlags=1111, Cond=AL -> all strobes 0, Flags unchanged, counters unchanged.

Source files
------------

// File: rtl/cond_logic.sv
// ARM condition/flag stage: holds NZCV, evaluates Cond, gates write strobes.
// Define COND_COUNTERS_EN to build the saturating executed/squashed counters.
module cond_logic (
    input  logic        clk,
    input  logic        reset,
    input  logic        Valid,
    input  logic [3:0]  Cond,
    input  logic [3:0]  ALUFlags,
    input  logic [1:0]  FlagW,
    input  logic        PCS,
    input  logic        RegW,
    input  logic        MemW,
    input  logic        NoWrite,
    output logic        PCSrc,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        CondEx,
    output logic [3:0]  Flags,
    output logic [15:0] ExecCount,
    output logic [15:0] SquashCount
);

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned CNT_W  = 16;

    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              n_f, z_f, c_f, v_f;
    logic              cond_ex;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    // Condition check always uses the stored flags, never same-cycle ALUFlags
    always_comb begin
        cond_ex = 1'b0;
        unique case (Cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            4'b1111: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

    assign CondEx   = cond_ex;
    assign PCSrc    = PCS & cond_ex & Valid;
    assign RegWrite = RegW & ~NoWrite & cond_ex & Valid;
    assign MemWrite = MemW & cond_ex & Valid;
    assign Flags    = flags_q;

    // NZ and CV halves load independently; squashed instructions never touch flags
    always_comb begin
        flags_d = flags_q;
        if (Valid && cond_ex) begin
            if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
            if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) flags_q <= '0;
        else       flags_q <= flags_d;
    end

`ifdef COND_COUNTERS_EN
    logic [CNT_W-1:0] exec_q, exec_d;
    logic [CNT_W-1:0] squash_q, squash_d;

    // Saturating debug counters
    always_comb begin
        exec_d   = exec_q;
        squash_d = squash_q;
        if (Valid && cond_ex && (exec_q != {CNT_W{1'b1}}))
            exec_d = exec_q + CNT_W'(1);
        if (Valid && !cond_ex && (squash_q != {CNT_W{1'b1}}))
            squash_d = squash_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exec_q   <= '0;
            squash_q <= '0;
        end else begin
            exec_q   <= exec_d;
            squash_q <= squash_d;
        end
    end

    assign ExecCount   = exec_q;
    assign SquashCount = squash_q;
`else
    assign ExecCount   = 16'h0000;
    assign SquashCount = 16'h0000;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard bench for cond_logic; counter expectations follow COND_COUNTERS_EN.
module tb_cond_logic;

    logic        clk = 1'b0;
    logic        reset, Valid, PCS, RegW, MemW, NoWrite;
    logic [3:0]  Cond, ALUFlags;
    logic [1:0]  FlagW;
    logic        PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0]  Flags;
    logic [15:0] ExecCount, SquashCount;

    cond_logic dut (
        .clk(clk), .reset(reset), .Valid(Valid), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
        .Flags(Flags), .ExecCount(ExecCount), .SquashCount(SquashCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pcsrc, regwrite, memwrite, condex;
        logic [3:0]  flags;
        logic [15:0] exec, squash;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  m_flags;
    logic [15:0] m_exec, m_squash;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: base test per Cond[3:1], Cond[0] inverts
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic step(input logic rst, input logic v, input logic [3:0] c, input logic [3:0] alu,
                        input logic [1:0] fw, input logic pcs, input logic regw,
                        input logic memw, input logic nowr);
        exp_t e, g;
        logic ce;
        @(negedge clk);
        reset = rst; Valid = v; Cond = c; ALUFlags = alu; FlagW = fw;
        PCS = pcs; RegW = regw; MemW = memw; NoWrite = nowr;
        ce = cond_pass(c, m_flags);
        e.condex   = ce;
        e.pcsrc    = pcs & ce & v;
        e.regwrite = regw & ~nowr & ce & v;
        e.memwrite = memw & ce & v;
        e.flags    = m_flags;
        e.exec     = m_exec;
        e.squash   = m_squash;
        sb.push_back(e);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            g = sb.pop_front();
            check("CondEx",      32'(CondEx),      32'(g.condex));
            check("PCSrc",       32'(PCSrc),       32'(g.pcsrc));
            check("RegWrite",    32'(RegWrite),    32'(g.regwrite));
            check("MemWrite",    32'(MemWrite),    32'(g.memwrite));
            check("Flags",       32'(Flags),       32'(g.flags));
            check("ExecCount",   32'(ExecCount),   32'(g.exec));
            check("SquashCount", 32'(SquashCount), 32'(g.squash));
        end
        // Model the upcoming rising edge
        if (rst) begin
            m_flags = '0; m_exec = '0; m_squash = '0;
        end else if (v) begin
            if (ce) begin
                if (fw[1]) m_flags[3:2] = alu[3:2];
                if (fw[0]) m_flags[1:0] = alu[1:0];
`ifdef COND_COUNTERS_EN
                if (m_exec != 16'hFFFF) m_exec = m_exec + 16'd1;
`endif
            end else begin
`ifdef COND_COUNTERS_EN
                if (m_squash != 16'hFFFF) m_squash = m_squash + 16'd1;
`endif
            end
        end
    endtask

    initial begin
        reset = 1'b1; Valid = 1'b0; Cond = 4'hE; ALUFlags = '0; FlagW = '0;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
        m_flags = '0; m_exec = '0; m_squash = '0;
        repeat (2) @(posedge clk);

        // Post-reset: EQ fails, NE passes
        step(0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
        step(0, 0, 4'h1, 4'h0, 2'b00, 0, 0, 0, 0);

        // AL writes reg and sets Z; EQ then passes
        step(0, 1, 4'hE, 4'b0100, 2'b11, 0, 1, 0, 0);
        step(0, 1, 4'h0, 4'b0000, 2'b00, 0, 1, 0, 0);

        // NE squashed: no strobes, flags hold, squash count
        step(0, 1, 4'h1, 4'b1000, 2'b11, 1, 0, 1, 0);
        step(0, 0, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0);

        // Independent flag halves
        step(1, 0, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0);
        step(0, 1, 4'hE, 4'b1111, 2'b10, 0, 0, 0, 0);
        step(0, 1, 4'hE, 4'b0011, 2'b01, 0, 0, 0, 0);
        step(0, 0, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0);

        // Valid low: nothing updates, strobes low
        step(0, 0, 4'hE, 4'b0000, 2'b11, 1, 1, 1, 0);
        step(0, 0, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0);

        // Reset dominates a valid flag-setting instruction
        step(0, 1, 4'hE, 4'b1111, 2'b11, 0, 0, 0, 0);
        step(1, 1, 4'hE, 4'b0101, 2'b11, 1, 1, 1, 0);
        step(0, 1, 4'h0, 4'b0000, 2'b00, 1, 1, 1, 0);

        // Full Cond x Flags sweep, with NoWrite toggled
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                step(0, 1, 4'hE, 4'(f), 2'b11, 0, 0, 0, 0);
                step(0, 1, 4'(c), 4'(15 - f), 2'(c), 1, 1, 1, 1'(c >> 1));
            end
        end

        // Random traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 31) == 0), 1'($urandom), 4'($urandom), 4'($urandom),
                 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

`ifdef COND_COUNTERS_EN
        // Saturation: clear, run 65535 executed cycles, then one more
        step(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0; Valid = 1'b1; Cond = 4'hE; FlagW = 2'b00;
        repeat (65535) @(posedge clk);
        m_exec = 16'hFFFF;
        step(0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        step(0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        step(0, 0, 4'hF, 4'h0, 2'b11, 0, 0, 0, 0);
        step(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        step(0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
